stepper_phase_sequencer: RTL and testbench
==========================================

# stepper_phase_sequencer

Drives a 4-coil unipolar stepper motor from the 4-bit control word produced by the system's Avalon-MM output PIO. It sits directly downstream of that PIO: the PIO's 4-bit output port feeds `ctrl`, and this block turns it into timed coil phase patterns. It also produces a step strobe and a 16-bit wrapping position count. Software controls enable, direction and speed only by writing the PIO data register.

## Interface
- `DIV_BASE`, default 50000: clock cycles per step at speed code 0. Legal range 2 to 2^28.
- `HALF_STEP`, default 0: 0 selects full-step wave drive (4 patterns); 1 selects half-step (8 patterns).
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset. Asynchronous assert, active-low. The clock is `clk`.
- `ctrl`  in  4  control word from the PIO, same clock domain:
  - [0] enable.
  - [1] direction: 1 = forward, 0 = reverse.
  - [3:2] speed code.
- `phase`  out  4  coil drive, registered. Bit n drives coil n.
- `step_pulse`  out  1  one-cycle strobe, high in the cycle a new pattern appears on `phase`.
- `position`  out  16  signed step count, registered. It wraps modulo 2^16.

## Operation
- Input register: `ctrl` is captured every edge into `en_q`, `dir_q` and `spd_q`. All internal logic uses only the registered copies.
- Pattern table, indexed by 3-bit `idx`: 0:0001, 1:0011, 2:0010, 3:0110, 4:0100, 5:1100, 6:1000, 7:1001.
- Step increment `inc` is 2 when HALF_STEP=0 and 1 when HALF_STEP=1.
  - With inc=2 the sequence is 0001→0010→0100→1000, i.e. wave drive.
- Step period: `period = DIV_BASE << spd_q`, which is 1x, 2x, 4x or 8x the base.
  - Held in a 32-bit register.
  - Loaded every cycle while `en_q`=0, and at every step tick.
  - A speed change while running takes effect after the next step.
- Counter `count`, 32-bit:
  - While `en_q`=0: held at 0.
  - While `en_q`=1: increments by 1 each cycle.
- Tick occurs when `en_q`=1 and `count == period-1`. On the tick edge, all of these update together:
  - `count` ← 0.
  - `idx` ← `idx + inc` when `dir_q`=1, else `idx - inc` (mod 8).
  - `phase` ← TABLE[new idx].
  - `position` ← `position` ± 1, same sign as the direction.
  - `step_pulse` ← 1.
  - `period` reloads.
- Every non-tick edge: `step_pulse` ← 0.
  - If `en_q`=1, `phase` ← TABLE[idx].
  - If `en_q`=0, `phase` ← 0000 (coils de-energised).
- Disable: `idx` and `position` are retained, so re-enabling resumes from the same pattern with no step lost or added.
- Direction change mid-period: does not reset `count`. The new direction applies at the next tick.
- Wrap-around:
  - `idx` wraps mod 8, so in full-step mode an odd `idx` never occurs.
  - `position` wraps 32767 → -32768 and -32768 → 32767.
- Reset, including mid-operation: `phase`=0000, `step_pulse`=0, `position`=0, `idx`=0, `count`=0, `en_q`/`dir_q`/`spd_q`=0, `period`=DIV_BASE. Values apply immediately on assertion.

## Timing
- Reference point: a PIO write lands on `ctrl` after edge E0.
  - `en_q` is set at E1.
  - `phase` shows TABLE[idx] from E2.
- First tick: at edge E1 + period, with `period` taken from the `spd_q` captured at E1.
  - This is a fixed `period` cycles after `en_q` rises.
  - Subsequent ticks come exactly `period` cycles apart.
- Disable: `ctrl[0]` falling leads to `phase`=0000 two edges later. Any tick in flight is cancelled.
- `step_pulse` is high for exactly one cycle per step. It is never high while `en_q`=0.
- No combinational path exists from `ctrl` to any output.

## Test plan
- Reset release, `ctrl`=0000 for 20 cycles → `phase`=0000, `step_pulse`=0, `position`=0 throughout.
- DIV_BASE=4, HALF_STEP=0, `ctrl`=0011 → `phase`=0001 two cycles after the write, then the sequence 0010, 0100, 1000, 0001 every 4 cycles. Each change is coincident with `step_pulse`. `position` counts 1, 2, 3, 4.
- DIV_BASE=4, HALF_STEP=1, `ctrl`=0001 (reverse) from `idx`=0 → `phase` steps 1001, 1000, 1100 every 4 cycles. `position` counts -1, -2, -3.
- Speed code 3 (`ctrl`=1101) with DIV_BASE=4 → ticks 32 cycles apart. Changing to speed 0 mid-period → one more 32-cycle interval, then 4-cycle intervals.
- Disable after 3 forward steps, wait 10 cycles, re-enable:
  - While disabled: `phase`=0000, `position` holds 3.
  - On re-enable: resumes at 1000 (TABLE[6]), and the next step gives 0001.
- Preload `position` to 32767 by stepping, then 1 forward step → -32768. Assert `reset_n` mid-period → all outputs 0 immediately.

Source files
------------

// File: rtl/stepper_phase_sequencer.sv
// Unipolar 4-coil stepper sequencer driven by a PIO control word.
// Produces timed coil patterns, a step strobe and a wrapping position.
module stepper_phase_sequencer #(
    parameter int unsigned DIV_BASE  = 50000,
    parameter bit          HALF_STEP = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         ctrl,
    output logic [3:0]         phase,
    output logic               step_pulse,
    output logic signed [15:0] position
);

    localparam logic [31:0] BASE = 32'(DIV_BASE);
    localparam logic [2:0]  INC  = HALF_STEP ? 3'd1 : 3'd2;

    function automatic logic [3:0] pattern(input logic [2:0] i);
        logic [3:0] p;
        p = 4'b0000;
        case (i)
            3'd0: p = 4'b0001;
            3'd1: p = 4'b0011;
            3'd2: p = 4'b0010;
            3'd3: p = 4'b0110;
            3'd4: p = 4'b0100;
            3'd5: p = 4'b1100;
            3'd6: p = 4'b1000;
            3'd7: p = 4'b1001;
            default: p = 4'b0000;
        endcase
        return p;
    endfunction

    logic        en_q;
    logic        dir_q;
    logic [1:0]  spd_q;
    logic [31:0] period;
    logic [31:0] count;
    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic        tick;
    logic        reload;

    assign tick     = en_q && (count == period - 32'd1);
    assign idx_next = dir_q ? idx + INC : idx - INC;
    // count sits at 0 while idle and on the first enabled cycle, so the
    // first period picks up the speed captured alongside the enable
    assign reload   = tick || (count == 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q  <= 1'b0;
            dir_q <= 1'b0;
            spd_q <= 2'd0;
        end else begin
            en_q  <= ctrl[0];
            dir_q <= ctrl[1];
            spd_q <= ctrl[3:2];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period <= BASE;
            count  <= 32'd0;
        end else begin
            if (reload) begin
                period <= BASE << spd_q;
            end
            if (!en_q || tick) begin
                count <= 32'd0;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= 3'd0;
            phase      <= 4'b0000;
            step_pulse <= 1'b0;
            position   <= 16'sd0;
        end else if (tick) begin
            idx        <= idx_next;
            phase      <= pattern(idx_next);
            step_pulse <= 1'b1;
            position   <= dir_q ? position + 16'sd1
                                : position - 16'sd1;
        end else begin
            step_pulse <= 1'b0;
            phase      <= en_q ? pattern(idx) : 4'b0000;
        end
    end

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Directed bench for stepper_phase_sequencer: full/half step,
// speed change, disable/resume, position wrap and async reset.
module tb_stepper_phase_sequencer;

    logic        clk;
    logic        reset_n;
    logic [3:0]  ctrl_a, ctrl_b, ctrl_c;
    logic [3:0]  phase_a, phase_b, phase_c;
    logic        pulse_a, pulse_b, pulse_c;
    logic [15:0] pos_a, pos_b, pos_c;

    int total = 0;
    int bad   = 0;
    int n;
    int badgap;

    logic [3:0] exp_f [5] = '{4'b0001, 4'b0010, 4'b0100,
                              4'b1000, 4'b0001};

    stepper_phase_sequencer #(.DIV_BASE(4), .HALF_STEP(1'b0)) u_a (
        .clk(clk), .reset_n(reset_n), .ctrl(ctrl_a),
        .phase(phase_a), .step_pulse(pulse_a), .position(pos_a)
    );

    stepper_phase_sequencer #(.DIV_BASE(4), .HALF_STEP(1'b1)) u_b (
        .clk(clk), .reset_n(reset_n), .ctrl(ctrl_b),
        .phase(phase_b), .step_pulse(pulse_b), .position(pos_b)
    );

    stepper_phase_sequencer #(.DIV_BASE(2), .HALF_STEP(1'b0)) u_c (
        .clk(clk), .reset_n(reset_n), .ctrl(ctrl_c),
        .phase(phase_c), .step_pulse(pulse_c), .position(pos_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    function automatic logic sel_pulse(input int w);
        case (w)
            0: return pulse_a;
            1: return pulse_b;
            default: return pulse_c;
        endcase
    endfunction

    task automatic wait_pulse(input int w, input int lim,
                              output int k);
        k = 0;
        do begin
            step(1);
            k++;
        end while (!sel_pulse(w) && k < lim);
    endtask

    task automatic do_reset();
        ctrl_a  = 4'b0000;
        ctrl_b  = 4'b0000;
        ctrl_c  = 4'b0000;
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        reset_n = 1'b0;
        ctrl_a  = 4'b0000;
        ctrl_b  = 4'b0000;
        ctrl_c  = 4'b0000;
        #1;
        chk("rst_phase", {28'd0, phase_a}, 32'h0);
        chk("rst_pulse", {31'd0, pulse_a}, 32'h0);
        chk("rst_pos", {16'd0, pos_a}, 32'h0);
        step(2);
        reset_n = 1'b1;

        // idle after reset release
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_phase", {28'd0, phase_a}, 32'h0);
            chk("idle_pulse", {31'd0, pulse_a}, 32'h0);
            chk("idle_pos", {16'd0, pos_a}, 32'h0);
            chk("idle_phase_b", {28'd0, phase_b}, 32'h0);
        end

        // full-step forward wave drive
        do_reset();
        ctrl_a = 4'b0011;
        step(1);
        chk("fs_e1_phase", {28'd0, phase_a}, 32'h0);
        for (int s = 1; s <= 4; s++) begin
            for (int q = 0; q < 3; q++) begin
                step(1);
                chk("fs_phase", {28'd0, phase_a}, {28'd0, exp_f[s-1]});
                chk("fs_quiet", {31'd0, pulse_a}, 32'h0);
                chk("fs_pos", {16'd0, pos_a}, 32'(s - 1));
            end
            step(1);
            chk("fs_tick_phase", {28'd0, phase_a}, {28'd0, exp_f[s]});
            chk("fs_tick_pulse", {31'd0, pulse_a}, 32'h1);
            chk("fs_tick_pos", {16'd0, pos_a}, 32'(s));
        end
        step(2);
        reset_n = 1'b0;
        #1;
        chk("midrst_phase", {28'd0, phase_a}, 32'h0);
        chk("midrst_pos", {16'd0, pos_a}, 32'h0);
        chk("midrst_pulse", {31'd0, pulse_a}, 32'h0);
        reset_n = 1'b1;

        // disable after three steps, then resume
        do_reset();
        ctrl_a = 4'b0011;
        step(4);
        for (int s = 1; s <= 3; s++) begin
            step(1);
            chk("dis_run_phase", {28'd0, phase_a}, {28'd0, exp_f[s]});
            chk("dis_run_pulse", {31'd0, pulse_a}, 32'h1);
            if (s < 3) step(3);
        end
        step(1);
        ctrl_a = 4'b0010;
        step(1);
        chk("dis_lag_phase", {28'd0, phase_a}, 32'h8);
        step(1);
        chk("dis_off_phase", {28'd0, phase_a}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("dis_phase", {28'd0, phase_a}, 32'h0);
            chk("dis_pulse", {31'd0, pulse_a}, 32'h0);
            chk("dis_pos", {16'd0, pos_a}, 32'h3);
        end
        ctrl_a = 4'b0011;
        step(1);
        chk("re_e1_phase", {28'd0, phase_a}, 32'h0);
        step(1);
        chk("re_phase", {28'd0, phase_a}, 32'h8);
        chk("re_pos", {16'd0, pos_a}, 32'h3);
        step(2);
        chk("re_quiet", {31'd0, pulse_a}, 32'h0);
        step(1);
        chk("re_tick_phase", {28'd0, phase_a}, 32'h1);
        chk("re_tick_pulse", {31'd0, pulse_a}, 32'h1);
        chk("re_tick_pos", {16'd0, pos_a}, 32'h4);

        // speed 3 reverse, then speed 0 mid-period
        do_reset();
        ctrl_a = 4'b1101;
        wait_pulse(0, 100, n);
        chk("spd_first_gap", 32'(n), 32'd33);
        chk("spd_phase1", {28'd0, phase_a}, 32'h8);
        chk("spd_pos1", {16'd0, pos_a}, 32'hffff);
        step(10);
        ctrl_a = 4'b0001;
        wait_pulse(0, 100, n);
        chk("spd_gap2", 32'(n), 32'd22);
        chk("spd_phase2", {28'd0, phase_a}, 32'h4);
        wait_pulse(0, 100, n);
        chk("spd_gap3", 32'(n), 32'd4);
        chk("spd_phase3", {28'd0, phase_a}, 32'h2);
        wait_pulse(0, 100, n);
        chk("spd_gap4", 32'(n), 32'd4);
        chk("spd_phase4", {28'd0, phase_a}, 32'h1);
        chk("spd_pos4", {16'd0, pos_a}, 32'hfffc);

        // half-step reverse, then direction flip mid-period
        do_reset();
        ctrl_b = 4'b0001;
        wait_pulse(1, 20, n);
        chk("hs_gap1", 32'(n), 32'd5);
        chk("hs_phase1", {28'd0, phase_b}, 32'h9);
        chk("hs_pos1", {16'd0, pos_b}, 32'hffff);
        wait_pulse(1, 20, n);
        chk("hs_gap2", 32'(n), 32'd4);
        chk("hs_phase2", {28'd0, phase_b}, 32'h8);
        chk("hs_pos2", {16'd0, pos_b}, 32'hfffe);
        wait_pulse(1, 20, n);
        chk("hs_gap3", 32'(n), 32'd4);
        chk("hs_phase3", {28'd0, phase_b}, 32'hc);
        chk("hs_pos3", {16'd0, pos_b}, 32'hfffd);
        step(1);
        ctrl_b = 4'b0011;
        wait_pulse(1, 20, n);
        chk("dir_gap", 32'(n), 32'd3);
        chk("dir_phase", {28'd0, phase_b}, 32'h8);
        chk("dir_pos", {16'd0, pos_b}, 32'hfffe);

        // position wrap on the fast instance
        do_reset();
        ctrl_c = 4'b0011;
        wait_pulse(2, 10, n);
        chk("wrap_first_gap", 32'(n), 32'd3);
        badgap = 0;
        for (int i = 2; i <= 32767; i++) begin
            wait_pulse(2, 10, n);
            if (n != 2) badgap++;
        end
        chk("wrap_gaps", 32'(badgap), 32'd0);
        chk("wrap_pos_max", {16'd0, pos_c}, 32'h7fff);
        chk("wrap_phase_max", {28'd0, phase_c}, 32'h8);
        wait_pulse(2, 10, n);
        chk("wrap_gap_fwd", 32'(n), 32'd2);
        chk("wrap_pos_min", {16'd0, pos_c}, 32'h8000);
        chk("wrap_phase_min", {28'd0, phase_c}, 32'h1);
        ctrl_c = 4'b0001;
        wait_pulse(2, 10, n);
        chk("wrap_gap_rev", 32'(n), 32'd2);
        chk("wrap_pos_back", {16'd0, pos_c}, 32'h7fff);
        chk("wrap_phase_back", {28'd0, phase_c}, 32'h8);
        step(1);
        reset_n = 1'b0;
        #1;
        chk("end_rst_pos", {16'd0, pos_c}, 32'h0);
        chk("end_rst_phase", {28'd0, phase_c}, 32'h0);
        chk("end_rst_pulse", {31'd0, pulse_c}, 32'h0);
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
